bcd_down_counter: RTL and testbench



---
 rtl/bcd_down_counter_pkg.sv | 10 +
 rtl/bcd_down_counter_if.sv | 13 +
 rtl/bcd_down_digit.sv | 20 ++
 rtl/bcd_down_counter.sv | 41 ++++
 tb/tb_bcd_down_counter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared BCD digit constants and load clamp helper
package bcd_down_counter_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;
  function automatic bcd_t bcd_clamp(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: load/count/status bundle between a controller and the counter
interface bcd_down_counter_if #(parameter int DIGITS = 4);
  import bcd_down_counter_pkg::*;
  logic Load;
  logic [DIGIT_W*DIGITS-1:0] Load_val;
  logic Bin;
  logic [DIGIT_W*DIGITS-1:0] q;
  logic Bout;
  logic Zero;
  logic Load_err;
  modport master(output Load, Load_val, Bin, input q, Bout, Zero, Load_err);
  modport slave(input Load, Load_val, Bin, output q, Bout, Zero, Load_err);
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit of the down-counter with borrow output
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic Load,
  input  bcd_t Load_digit,
  input  logic Bin,
  input  logic Wrap,
  output bcd_t d,
  output logic Bout_digit
);
  bcd_t d_q, d_d;
  // a zero digit either rolls to 9 or, when the whole counter saturates, holds
  always_comb d_d = Load ? Load_digit : !Bin ? d_q : (d_q == BCD_ZERO) ? (Wrap ? BCD_MAX : BCD_ZERO) : d_q - 4'd1;
  always_ff @(posedge Clk) d_q <= Rst ? BCD_ZERO : d_d;
  assign d = d_q;
  assign Bout_digit = Bin & (d_q == BCD_ZERO);
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown with borrow chain, clamped load and zero flag
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input logic Clk,
  input logic Rst,
  bcd_down_counter_if.slave bus
);
  logic [DIGITS:0] borrow;
  logic [DIGITS-1:0] clamped;
  logic [DIGIT_W*DIGITS-1:0] q;
  logic zero, wrap, err_q, err_d;
  assign borrow[0] = bus.Bin;
  assign zero = (q == '0);
  // lower digits must still roll over when a higher digit is nonzero
  assign wrap = WRAP_EN || !zero;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_t raw;
    assign raw = bus.Load_val[DIGIT_W*i +: DIGIT_W];
    assign clamped[i] = raw > BCD_MAX;
    bcd_down_digit u_digit (
      .Clk(Clk),
      .Rst(Rst),
      .Load(bus.Load),
      .Load_digit(bcd_clamp(raw)),
      .Bin(borrow[i]),
      .Wrap(wrap),
      .d(q[DIGIT_W*i +: DIGIT_W]),
      .Bout_digit(borrow[i+1])
    );
  end
  assign err_d = bus.Load & |clamped;
  always_ff @(posedge Clk) err_q <= Rst ? 1'b0 : err_d;
  assign bus.q = q;
  assign bus.Zero = zero;
  assign bus.Load_err = err_q;
  assign bus.Bout = borrow[DIGITS] & ~bus.Load & ~Rst;
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: scoreboard bench for wrap, saturate and cascaded 2-digit counters
module tb_bcd_down_counter;
  typedef struct {
    int sel;
    logic [7:0] q;
    logic bout;
    logic err;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  logic [10:0] act, want;
  bcd_down_counter_if #(.DIGITS(2)) ifw ();
  bcd_down_counter_if #(.DIGITS(2)) ifs ();
  bcd_down_counter_if #(.DIGITS(2)) ifl ();
  bcd_down_counter_if #(.DIGITS(2)) ifh ();
  bcd_down_counter #(.DIGITS(2), .WRAP_EN(1'b1)) dut_w (.Clk(clk), .Rst(rst), .bus(ifw));
  bcd_down_counter #(.DIGITS(2), .WRAP_EN(1'b0)) dut_s (.Clk(clk), .Rst(rst), .bus(ifs));
  bcd_down_counter #(.DIGITS(2), .WRAP_EN(1'b1)) dut_l (.Clk(clk), .Rst(rst), .bus(ifl));
  bcd_down_counter #(.DIGITS(2), .WRAP_EN(1'b1)) dut_h (.Clk(clk), .Rst(rst), .bus(ifh));
  assign ifs.Load = ifw.Load;
  assign ifs.Load_val = ifw.Load_val;
  assign ifs.Bin = ifw.Bin;
  assign ifh.Bin = ifl.Bout;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0: act = {ifw.q, ifw.Bout, ifw.Zero, ifw.Load_err};
        1: act = {ifs.q, ifs.Bout, ifs.Zero, ifs.Load_err};
        2: act = {ifl.q, ifl.Bout, ifl.Zero, ifl.Load_err};
        default: act = {ifh.q, ifh.Bout, ifh.Zero, ifh.Load_err};
      endcase
      want = {e.q, e.bout, e.q == 8'h00, e.err};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s dut%0d got q=%h bout=%b zero=%b err=%b want q=%h bout=%b zero=%b err=%b",
                 e.name, e.sel, act[10:3], act[2], act[1], act[0], want[10:3], want[2], want[1], want[0]);
      end
    end
  end
  task automatic ex(input int sel, input logic [7:0] q, input logic bout, input logic err, input string name);
    sb.push_back('{sel, q, bout, err, name});
  endtask
  task automatic exb(input logic [7:0] qw, input logic [7:0] qs, input logic bw, input logic bs, input logic err, input string name);
    ex(0, qw, bw, err, name);
    ex(1, qs, bs, err, name);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic r, input logic l, input logic [7:0] v, input logic b);
    tick();
    rst = r;
    ifw.Load = l;
    ifw.Load_val = v;
    ifw.Bin = b;
  endtask
  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  initial begin
    rst = 1'b1;
    ifw.Load = 1'b1;
    ifw.Load_val = 8'h45;
    ifw.Bin = 1'b1;
    ifl.Load = 1'b0;
    ifl.Load_val = 8'h00;
    ifl.Bin = 1'b0;
    ifh.Load = 1'b0;
    ifh.Load_val = 8'h00;
    repeat (5) begin
      step(1, 1, 8'h45, 1);
      exb(8'h00, 8'h00, 0, 0, 0, "reset");
      ex(2, 8'h00, 0, 0, "reset_lo");
      ex(3, 8'h00, 0, 0, "reset_hi");
    end
    step(0, 0, 8'h00, 0); exb(8'h00, 8'h00, 0, 0, 0, "idle_zero_bout");
    step(0, 1, 8'h21, 0); exb(8'h00, 8'h00, 0, 0, 0, "load21_issue");
    step(0, 0, 8'h00, 1); exb(8'h21, 8'h21, 0, 0, 0, "load21");
    step(0, 0, 8'h00, 1); exb(8'h20, 8'h20, 0, 0, 0, "dec20");
    step(0, 0, 8'h00, 1); exb(8'h19, 8'h19, 0, 0, 0, "dec19");
    step(0, 0, 8'h00, 0); exb(8'h18, 8'h18, 0, 0, 0, "dec18");
    step(0, 1, 8'h01, 1); exb(8'h18, 8'h18, 0, 0, 0, "load01_issue");
    step(0, 0, 8'h00, 1); exb(8'h01, 8'h01, 0, 0, 0, "load01");
    step(0, 0, 8'h00, 1); exb(8'h00, 8'h00, 1, 1, 0, "underflow");
    step(0, 0, 8'h00, 1); exb(8'h99, 8'h00, 0, 1, 0, "wrap_or_sat");
    step(0, 0, 8'h00, 1); exb(8'h98, 8'h00, 0, 1, 0, "after_wrap");
    step(0, 0, 8'h00, 0); exb(8'h97, 8'h00, 0, 0, 0, "bin_low");
    step(0, 1, 8'hA7, 0); exb(8'h97, 8'h00, 0, 0, 0, "loadA7_issue");
    step(0, 0, 8'h00, 0); exb(8'h97, 8'h97, 0, 0, 1, "clamp_err");
    step(0, 1, 8'h34, 0); exb(8'h97, 8'h97, 0, 0, 0, "err_one_cycle");
    step(0, 0, 8'h00, 0); exb(8'h34, 8'h34, 0, 0, 0, "load34");
    step(0, 1, 8'h00, 0); exb(8'h34, 8'h34, 0, 0, 0, "load00_issue");
    step(0, 1, 8'h50, 1); exb(8'h00, 8'h00, 0, 0, 0, "load_vs_bin");
    step(0, 0, 8'h00, 0); exb(8'h50, 8'h50, 0, 0, 0, "load50");
    step(1, 1, 8'hFF, 1); exb(8'h50, 8'h50, 0, 0, 0, "rst_vs_load");
    step(0, 0, 8'h00, 0); exb(8'h00, 8'h00, 0, 0, 0, "rst_clears_err");
    tick();
    ifl.Load = 1'b1; ifh.Load = 1'b1;
    ex(2, 8'h00, 0, 0, "casc_load0"); ex(3, 8'h00, 0, 0, "casc_load0");
    tick();
    ifl.Load = 1'b0; ifh.Load_val = 8'h02;
    ex(2, 8'h00, 0, 0, "casc_load2"); ex(3, 8'h00, 0, 0, "casc_load2");
    tick();
    ifh.Load = 1'b0; ifl.Bin = 1'b1;
    ex(2, 8'h00, 1, 0, "casc_start"); ex(3, 8'h02, 0, 0, "casc_start");
    for (int k = 1; k <= 150; k++) begin
      int l;
      int h;
      tick();
      if (k == 150) rst = 1'b1;
      l = (100 - k % 100) % 100;
      h = (k <= 100) ? 1 : 0;
      ex(2, bcd2(l), l == 0, 0, "casc_lo");
      ex(3, bcd2(h), (h == 0) && (l == 0), 0, "casc_hi");
    end
    tick();
    rst = 1'b0; ifl.Bin = 1'b0;
    ex(2, 8'h00, 0, 0, "casc_rst"); ex(3, 8'h00, 0, 0, "casc_rst");
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
